// File: rtl/inta_sequencer_if.sv
// Signal bundle between the CPU/request side and the interrupt acknowledge sequencer.
interface inta_sequencer_if;
  logic [7:0] irr;
  logic [7:0] imr;
  logic       inta_n;
  logic       aeoi;
  logic       eoi_ns;
  logic       eoi_sp;
  logic [2:0] eoi_level;
  logic [4:0] vec_base;
  logic       int_out;
  logic [7:0] isr;
  logic [7:0] vector;
  logic       vector_valid;
  logic [7:0] clr_irr;

  modport master (
    output irr, imr, inta_n, aeoi, eoi_ns, eoi_sp, eoi_level, vec_base,
    input  int_out, isr, vector, vector_valid, clr_irr
  );

  modport slave (
    input  irr, imr, inta_n, aeoi, eoi_ns, eoi_sp, eoi_level, vec_base,
    output int_out, isr, vector, vector_valid, clr_irr
  );
endinterface

// File: rtl/inta_sequencer.sv
// Fully nested interrupt priority resolver with a two-edge INTA acknowledge sequence.
// Optional automatic priority rotation on EOI is enabled by defining AUTO_ROTATE_EN.
module inta_sequencer (
  input logic              clk,
  input logic              rst_n,
  inta_sequencer_if.slave  bus
);

  typedef enum logic {StIdle, StAck1} state_e;

  // Rank 0 is highest priority; 8 means no bit set.
  function automatic logic [3:0] top_rank(input logic [7:0] vec, input logic [2:0] lp);
    logic [3:0] rank;
    logic [2:0] idx;
    rank = 4'd8;
    for (int k = 7; k >= 0; k--) begin
      idx = lp + 3'd1 + 3'(k);
      if (vec[idx]) rank = 4'(k);
    end
    return rank;
  endfunction

  state_e     r_state;
  logic [7:0] r_isr;
  logic [7:0] r_vector;
  logic       r_vector_valid;
  logic [7:0] r_clr_irr;
  logic       r_int_out;
  logic [2:0] r_level;
  logic       r_spurious;
  logic       r_inta_prev;

  logic [2:0] w_lowest_pri;
  logic [7:0] w_req;
  logic [3:0] w_req_rank;
  logic [3:0] w_isr_rank;
  logic       w_cand;
  logic [2:0] w_cand_level;
  logic       w_fall;
  logic       w_first;
  logic       w_second;
  logic       w_eoi_hit;
  logic [2:0] w_eoi_lvl;
  logic       w_aeoi_hit;
  logic [7:0] w_clr_mask;
  logic [7:0] w_set_mask;
  logic [7:0] w_isr_d;

`ifdef AUTO_ROTATE_EN
  logic [2:0] r_lowest_pri;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lowest_pri <= 3'd7;
    end else if (w_eoi_hit) begin
      r_lowest_pri <= w_eoi_lvl;
    end else if (w_aeoi_hit) begin
      r_lowest_pri <= r_level;
    end
  end

  assign w_lowest_pri = r_lowest_pri;
`else
  assign w_lowest_pri = 3'd7;
`endif

  assign w_req        = bus.irr & ~bus.imr;
  assign w_req_rank   = top_rank(w_req, w_lowest_pri);
  assign w_isr_rank   = top_rank(r_isr, w_lowest_pri);
  // An empty isr ranks 8, so any real request beats it.
  assign w_cand       = (w_req_rank < w_isr_rank);
  assign w_cand_level = w_lowest_pri + 3'd1 + w_req_rank[2:0];

  assign w_fall   = r_inta_prev & ~bus.inta_n;
  assign w_first  = w_fall && (r_state == StIdle);
  assign w_second = w_fall && (r_state == StAck1);

  always_comb begin
    w_eoi_hit = 1'b0;
    w_eoi_lvl = 3'd0;
    if (bus.eoi_sp) begin
      w_eoi_lvl = bus.eoi_level;
      w_eoi_hit = r_isr[bus.eoi_level];
    end else if (bus.eoi_ns && (w_isr_rank != 4'd8)) begin
      w_eoi_lvl = w_lowest_pri + 3'd1 + w_isr_rank[2:0];
      w_eoi_hit = 1'b1;
    end
  end

  assign w_aeoi_hit = w_second && bus.aeoi && !r_spurious;
  assign w_clr_mask = (w_eoi_hit ? (8'b1 << w_eoi_lvl) : 8'h00)
                    | (w_aeoi_hit ? (8'b1 << r_level) : 8'h00);
  assign w_set_mask = (w_first && w_cand) ? (8'b1 << w_cand_level) : 8'h00;
  // Set is applied after clear so a same-bit collision keeps the bit set.
  assign w_isr_d    = (r_isr & ~w_clr_mask) | w_set_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= StIdle;
      r_isr          <= 8'h00;
      r_vector       <= 8'h00;
      r_vector_valid <= 1'b0;
      r_clr_irr      <= 8'h00;
      r_int_out      <= 1'b0;
      r_level        <= 3'd7;
      r_spurious     <= 1'b0;
      r_inta_prev    <= 1'b1;
    end else begin
      r_inta_prev    <= bus.inta_n;
      r_isr          <= w_isr_d;
      r_vector_valid <= 1'b0;
      r_clr_irr      <= 8'h00;
      r_int_out      <= (r_state == StIdle) && !w_fall && w_cand;
      case (r_state)
        StIdle: begin
          if (w_fall) begin
            r_state    <= StAck1;
            r_level    <= w_cand ? w_cand_level : 3'd7;
            r_spurious <= !w_cand;
            r_clr_irr  <= w_set_mask;
          end
        end
        StAck1: begin
          if (w_fall) begin
            r_state        <= StIdle;
            r_vector       <= {bus.vec_base, r_level};
            r_vector_valid <= 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.int_out      = r_int_out;
  assign bus.isr          = r_isr;
  assign bus.vector       = r_vector;
  assign bus.vector_valid = r_vector_valid;
  assign bus.clr_irr      = r_clr_irr;

endmodule

// File: tb/tb_inta_sequencer.sv
// Directed self-checking bench for inta_sequencer; priority test adapts to AUTO_ROTATE_EN.
module tb_inta_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  inta_sequencer_if sif ();

  inta_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n         = 1'b0;
    sif.irr       = 8'h00;
    sif.imr       = 8'h00;
    sif.inta_n    = 1'b1;
    sif.aeoi      = 1'b0;
    sif.eoi_ns    = 1'b0;
    sif.eoi_sp    = 1'b0;
    sif.eoi_level = 3'd0;
    sif.vec_base  = 5'h00;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    do_reset();
    sif.irr = 8'hFF;
    rst_n   = 1'b0;
    tick();
    checks++;
    if ({sif.int_out, sif.isr, sif.vector, sif.vector_valid, sif.clr_irr} !== 26'd0) begin
      errors++;
      $display("FAIL reset_outputs: got int=%b isr=%h vec=%h vv=%b clr=%h want all zero",
               sif.int_out, sif.isr, sif.vector, sif.vector_valid, sif.clr_irr);
    end
    rst_n   = 1'b1;
    sif.irr = 8'h00;
    tick();
    checks++;
    if (sif.int_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_int: got %b want 0", sif.int_out);
    end
  endtask

  // irr=0x24: IR2 wins, then nested IR0 preempts while IR2 is in service.
  task automatic test_basic_and_nested;
    do_reset();
    sif.irr      = 8'h24;
    sif.vec_base = 5'h08;
    tick();
    checks++;
    if (sif.int_out !== 1'b1) begin
      errors++; $display("FAIL basic_int_out: got %b want 1", sif.int_out);
    end
    sif.inta_n = 1'b0;
    tick();
    checks++;
    if ({sif.isr, sif.clr_irr, sif.int_out} !== {8'h04, 8'h04, 1'b0}) begin
      errors++;
      $display("FAIL basic_first_edge: got isr=%h clr=%h int=%b want isr=04 clr=04 int=0",
               sif.isr, sif.clr_irr, sif.int_out);
    end
    sif.irr    = 8'h20;
    sif.inta_n = 1'b1;
    tick();
    checks++;
    if ({sif.clr_irr, sif.vector_valid} !== {8'h00, 1'b0}) begin
      errors++;
      $display("FAIL basic_clr_pulse: got clr=%h vv=%b want clr=00 vv=0",
               sif.clr_irr, sif.vector_valid);
    end
    sif.inta_n = 1'b0;
    tick();
    checks++;
    if ({sif.vector_valid, sif.vector} !== {1'b1, 8'h42}) begin
      errors++;
      $display("FAIL basic_vector: got vv=%b vec=%h want vv=1 vec=42",
               sif.vector_valid, sif.vector);
    end
    sif.inta_n = 1'b1;
    tick();
    checks++;
    if ({sif.vector_valid, sif.vector, sif.isr} !== {1'b0, 8'h42, 8'h04}) begin
      errors++;
      $display("FAIL basic_hold: got vv=%b vec=%h isr=%h want vv=0 vec=42 isr=04",
               sif.vector_valid, sif.vector, sif.isr);
    end
    sif.irr = 8'h08;
    tick();
    checks++;
    if (sif.int_out !== 1'b0) begin
      errors++; $display("FAIL nested_lower_blocked: got %b want 0", sif.int_out);
    end
    sif.irr = 8'h01;
    tick();
    checks++;
    if (sif.int_out !== 1'b1) begin
      errors++; $display("FAIL nested_higher_int: got %b want 1", sif.int_out);
    end
    sif.inta_n = 1'b0;
    tick();
    checks++;
    if ({sif.isr, sif.clr_irr} !== {8'h05, 8'h01}) begin
      errors++;
      $display("FAIL nested_isr: got isr=%h clr=%h want isr=05 clr=01", sif.isr, sif.clr_irr);
    end
    sif.irr    = 8'h00;
    sif.inta_n = 1'b1;
    tick();
    sif.inta_n = 1'b0;
    tick();
    checks++;
    if ({sif.vector_valid, sif.vector} !== {1'b1, 8'h40}) begin
      errors++;
      $display("FAIL nested_vector: got vv=%b vec=%h want vv=1 vec=40",
               sif.vector_valid, sif.vector);
    end
    sif.inta_n = 1'b1;
    tick();
  endtask

  // Continues from isr=0x05.
  task automatic test_eoi;
    sif.eoi_ns    = 1'b1;
    sif.eoi_sp    = 1'b1;
    sif.eoi_level = 3'd2;
    tick();
    sif.eoi_ns = 1'b0;
    sif.eoi_sp = 1'b0;
    checks++;
    if (sif.isr !== 8'h01) begin
      errors++; $display("FAIL eoi_sp_over_ns: got isr=%h want 01", sif.isr);
    end
    sif.eoi_sp    = 1'b1;
    sif.eoi_level = 3'd2;
    tick();
    sif.eoi_sp = 1'b0;
    checks++;
    if (sif.isr !== 8'h01) begin
      errors++; $display("FAIL eoi_sp_clear_bit: got isr=%h want 01", sif.isr);
    end
    sif.eoi_ns = 1'b1;
    tick();
    sif.eoi_ns = 1'b0;
    checks++;
    if (sif.isr !== 8'h00) begin
      errors++; $display("FAIL eoi_ns: got isr=%h want 00", sif.isr);
    end
    sif.eoi_ns = 1'b1;
    tick();
    sif.eoi_ns = 1'b0;
    checks++;
    if ({sif.isr, sif.vector_valid} !== {8'h00, 1'b0}) begin
      errors++;
      $display("FAIL eoi_ns_empty: got isr=%h vv=%b want isr=00 vv=0", sif.isr, sif.vector_valid);
    end
    sif.irr = 8'h01;
    tick();
    sif.inta_n    = 1'b0;
    sif.eoi_sp    = 1'b1;
    sif.eoi_level = 3'd0;
    tick();
    sif.eoi_sp = 1'b0;
    checks++;
    if ({sif.isr, sif.clr_irr} !== {8'h01, 8'h01}) begin
      errors++;
      $display("FAIL eoi_set_wins: got isr=%h clr=%h want isr=01 clr=01", sif.isr, sif.clr_irr);
    end
    sif.irr    = 8'h00;
    sif.inta_n = 1'b1;
    tick();
    sif.inta_n = 1'b0;
    tick();
    sif.inta_n = 1'b1;
    tick();
  endtask

  task automatic test_aeoi;
    do_reset();
    sif.aeoi     = 1'b1;
    sif.vec_base = 5'h08;
    sif.irr      = 8'h80;
    tick();
    sif.inta_n = 1'b0;
    tick();
    checks++;
    if ({sif.isr, sif.clr_irr} !== {8'h80, 8'h80}) begin
      errors++;
      $display("FAIL aeoi_first: got isr=%h clr=%h want isr=80 clr=80", sif.isr, sif.clr_irr);
    end
    sif.irr    = 8'h00;
    sif.inta_n = 1'b1;
    tick();
    sif.inta_n = 1'b0;
    tick();
    checks++;
    if ({sif.vector_valid, sif.vector, sif.isr} !== {1'b1, 8'h47, 8'h00}) begin
      errors++;
      $display("FAIL aeoi_vector: got vv=%b vec=%h isr=%h want vv=1 vec=47 isr=00",
               sif.vector_valid, sif.vector, sif.isr);
    end
    sif.inta_n = 1'b1;
    sif.aeoi   = 1'b0;
    tick();
  endtask

  task automatic test_spurious;
    do_reset();
    sif.vec_base = 5'h15;
    sif.irr      = 8'h02;
    tick();
    sif.inta_n = 1'b0;
    tick();
    sif.irr    = 8'h00;
    sif.inta_n = 1'b1;
    tick();
    sif.inta_n = 1'b0;
    tick();
    sif.inta_n = 1'b1;
    sif.irr    = 8'h01;
    tick();
    checks++;
    if ({sif.isr, sif.int_out} !== {8'h02, 1'b1}) begin
      errors++;
      $display("FAIL spur_setup: got isr=%h int=%b want isr=02 int=1", sif.isr, sif.int_out);
    end
    sif.irr = 8'h00;
    tick();
    checks++;
    if (sif.int_out !== 1'b0) begin
      errors++; $display("FAIL spur_int_drop: got %b want 0", sif.int_out);
    end
    sif.inta_n = 1'b0;
    tick();
    checks++;
    if ({sif.isr, sif.clr_irr} !== {8'h02, 8'h00}) begin
      errors++;
      $display("FAIL spur_first: got isr=%h clr=%h want isr=02 clr=00", sif.isr, sif.clr_irr);
    end
    sif.inta_n = 1'b1;
    tick();
    sif.inta_n = 1'b0;
    tick();
    checks++;
    if ({sif.vector_valid, sif.vector, sif.isr} !== {1'b1, 8'hAF, 8'h02}) begin
      errors++;
      $display("FAIL spur_vector: got vv=%b vec=%h isr=%h want vv=1 vec=af isr=02",
               sif.vector_valid, sif.vector, sif.isr);
    end
    sif.inta_n = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid;
    do_reset();
    sif.vec_base = 5'h08;
    sif.irr      = 8'h02;
    tick();
    sif.inta_n = 1'b0;
    tick();
    sif.inta_n = 1'b1;
    tick();
    rst_n = 1'b0;
    #2;
    checks++;
    if ({sif.int_out, sif.isr, sif.vector, sif.vector_valid, sif.clr_irr} !== 26'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got int=%b isr=%h vec=%h vv=%b clr=%h want all zero",
               sif.int_out, sif.isr, sif.vector, sif.vector_valid, sif.clr_irr);
    end
    tick();
    rst_n = 1'b1;
    tick();
    sif.inta_n = 1'b0;
    tick();
    checks++;
    if ({sif.vector_valid, sif.clr_irr, sif.isr} !== {1'b0, 8'h02, 8'h02}) begin
      errors++;
      $display("FAIL mid_reset_restart: got vv=%b clr=%h isr=%h want vv=0 clr=02 isr=02",
               sif.vector_valid, sif.clr_irr, sif.isr);
    end
    sif.irr    = 8'h00;
    sif.inta_n = 1'b1;
    tick();
    sif.inta_n = 1'b0;
    tick();
    checks++;
    if ({sif.vector_valid, sif.vector} !== {1'b1, 8'h41}) begin
      errors++;
      $display("FAIL mid_reset_vector: got vv=%b vec=%h want vv=1 vec=41",
               sif.vector_valid, sif.vector);
    end
    sif.inta_n = 1'b1;
    tick();
  endtask

  task automatic test_priority;
    do_reset();
    sif.vec_base = 5'h08;
    sif.irr      = 8'h04;
    tick();
    sif.inta_n = 1'b0;
    tick();
    sif.irr    = 8'h00;
    sif.inta_n = 1'b1;
    tick();
    sif.inta_n = 1'b0;
    tick();
    sif.inta_n    = 1'b1;
    sif.eoi_sp    = 1'b1;
    sif.eoi_level = 3'd2;
    tick();
    sif.eoi_sp = 1'b0;
    checks++;
    if (sif.isr !== 8'h00) begin
      errors++; $display("FAIL prio_eoi_sp: got isr=%h want 00", sif.isr);
    end
    sif.irr = 8'h0A;
    tick();
    sif.inta_n = 1'b0;
    tick();
`ifdef AUTO_ROTATE_EN
    checks++;
    if ({sif.clr_irr, sif.isr} !== {8'h08, 8'h08}) begin
      errors++;
      $display("FAIL prio_rotated: got clr=%h isr=%h want clr=08 isr=08", sif.clr_irr, sif.isr);
    end
    sif.irr = 8'h02;
`else
    checks++;
    if ({sif.clr_irr, sif.isr} !== {8'h02, 8'h02}) begin
      errors++;
      $display("FAIL prio_fixed: got clr=%h isr=%h want clr=02 isr=02", sif.clr_irr, sif.isr);
    end
    sif.irr = 8'h08;
`endif
    sif.inta_n = 1'b1;
    tick();
    sif.inta_n = 1'b0;
    tick();
    checks++;
`ifdef AUTO_ROTATE_EN
    if (sif.vector !== 8'h43) begin
      errors++; $display("FAIL prio_vector: got vec=%h want 43", sif.vector);
    end
`else
    if (sif.vector !== 8'h41) begin
      errors++; $display("FAIL prio_vector: got vec=%h want 41", sif.vector);
    end
`endif
    sif.inta_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic_and_nested();
    test_eoi();
    test_aeoi();
    test_spurious();
    test_reset_mid();
    test_priority();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
